// File: rtl/lap_timer_pkg.sv
// Shared types and constants for the lap timer: FSM states, BCD digit width,
// blank segment pattern and an MSD-first BCD magnitude compare.
package lap_timer_pkg;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 8;
   localparam int EXT_W      = BCD_W * MAX_DIGITS;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUNNING  = 2'd1,
      FINISHED = 2'd2
   } lap_state_e;

   // Callers zero-extend to MAX_DIGITS; equal leading zeros never decide.
   function automatic logic bcd_less(input logic [EXT_W-1:0] a, input logic [EXT_W-1:0] b);
      logic decided;
      logic lt;
      decided = 1'b0;
      lt      = 1'b0;
      for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
         if (!decided && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
            decided = 1'b1;
            lt      = (a[i*BCD_W +: BCD_W] < b[i*BCD_W +: BCD_W]);
         end
      end
      return lt;
   endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern, segment a at bit 0.
module hex7seg
   import lap_timer_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] segs
);

   always_comb begin
      segs = SEG_BLANK;
      case (hex)
         4'h0: segs = 7'h40;
         4'h1: segs = 7'h79;
         4'h2: segs = 7'h24;
         4'h3: segs = 7'h30;
         4'h4: segs = 7'h19;
         4'h5: segs = 7'h12;
         4'h6: segs = 7'h02;
         4'h7: segs = 7'h78;
         4'h8: segs = 7'h00;
         4'h9: segs = 7'h10;
         4'hA: segs = 7'h08;
         4'hB: segs = 7'h03;
         4'hC: segs = 7'h46;
         4'hD: segs = 7'h21;
         4'hE: segs = 7'h06;
         4'hF: segs = 7'h0E;
         default: segs = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/lap_timer_display_bcd_counter.sv
// Multi-digit BCD up-counter with ripple digit carry; holds at all 9s.
// clear and load_zero both zero the count and take priority over inc.
module bcd_counter
   import lap_timer_pkg::*;
#(
   parameter int NUM_DIGITS = 4
)(
   input  logic                        clk_sys,
   input  logic                        rst_b,
   input  logic                        clear,
   input  logic                        inc,
   input  logic                        load_zero,
   output logic [BCD_W*NUM_DIGITS-1:0] value
);

   logic [NUM_DIGITS-1:0][BCD_W-1:0] cnt_q;
   logic [NUM_DIGITS-1:0][BCD_W-1:0] cnt_inc;
   logic                             carry;

   // A carry surviving past the top digit means every digit was 9.
   always_comb begin
      cnt_inc = cnt_q;
      carry   = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (cnt_q[i] == 4'd9) begin
               cnt_inc[i] = 4'd0;
            end else begin
               cnt_inc[i] = cnt_q[i] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else if (clear || load_zero) begin
         cnt_q <= '0;
      end else if (inc && !carry) begin
         cnt_q <= cnt_inc;
      end
   end

   assign value = cnt_q;

endmodule

// File: rtl/lap_timer_display.sv
// Race/lap timer with BCD race and lap counters, lap counting to a finish and
// seven-segment output. Optional best-lap tracking under macro BEST_LAP_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | after reset, timers stopped, waiting for start_pulse
//   RUNNING  | prescaler ticking, race and lap counters advancing
//   FINISHED | NUM_LAPS done, everything frozen until start_pulse
module lap_timer_display
   import lap_timer_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 10,
   parameter int NUM_DIGITS = 4,
   parameter int NUM_LAPS   = 3
)(
   input  logic                        Clock,
   input  logic                        Resetn,
   input  logic                        start_pulse,
   input  logic                        lap_pulse,
   input  logic                        disp_sel,
   output logic                        running,
   output logic                        race_done,
   output logic [3:0]                  lap_count,
   output logic [BCD_W*NUM_DIGITS-1:0] race_bcd,
   output logic [BCD_W*NUM_DIGITS-1:0] best_bcd,
   output logic [7*NUM_DIGITS-1:0]     hex_segs
);

   localparam int W     = BCD_W * NUM_DIGITS;
   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(DIV - 1);
   localparam logic [3:0]       LAST_LAP = 4'(NUM_LAPS - 1);

   lap_state_e       state_q;
   lap_state_e       state_d;
   logic             start_evt;
   logic             lap_evt;
   logic             tick;
   logic [PRE_W-1:0] pre_q;
   logic [3:0]       lap_count_q;
   logic [W-1:0]     lap_bcd;
   logic [W-1:0]     disp_src;
   logic [W-1:0]     disp_q;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start_pulse) state_d = RUNNING;
         RUNNING:  if (lap_pulse && (lap_count_q == LAST_LAP)) state_d = FINISHED;
         FINISHED: if (start_pulse) state_d = RUNNING;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      running   = 1'b0;
      race_done = 1'b0;
      start_evt = 1'b0;
      lap_evt   = 1'b0;
      case (state_q)
         IDLE:     start_evt = start_pulse;
         RUNNING: begin
            running = 1'b1;
            lap_evt = lap_pulse;
         end
         FINISHED: begin
            race_done = 1'b1;
            start_evt = start_pulse;
         end
         default:  start_evt = 1'b0;
      endcase
   end

   // Down-counter reloaded at start, so the first tick lands DIV cycles later.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pre_q <= '0;
      end else if (start_evt) begin
         pre_q <= PRE_LOAD;
      end else if (!running) begin
         pre_q <= '0;
      end else if (pre_q == '0) begin
         pre_q <= PRE_LOAD;
      end else begin
         pre_q <= pre_q - PRE_W'(1);
      end
   end

   assign tick = running && (pre_q == '0);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         lap_count_q <= '0;
      end else if (start_evt) begin
         lap_count_q <= '0;
      end else if (lap_evt) begin
         lap_count_q <= lap_count_q + 4'd1;
      end
   end

   assign lap_count = lap_count_q;

   bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_race_cnt (
      .clk_sys   (Clock),
      .rst_b     (Resetn),
      .clear     (start_evt),
      .inc       (tick),
      .load_zero (1'b0),
      .value     (race_bcd)
   );

   bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_lap_cnt (
      .clk_sys   (Clock),
      .rst_b     (Resetn),
      .clear     (start_evt),
      .inc       (tick),
      .load_zero (lap_evt),
      .value     (lap_bcd)
   );

`ifdef BEST_LAP_EN
   logic [W-1:0] best_q;

   // lap_bcd is the pre-tick lap time, since the counter updates on this same edge.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         best_q <= {NUM_DIGITS{4'h9}};
      end else if (lap_evt && bcd_less(EXT_W'(lap_bcd), EXT_W'(best_q))) begin
         best_q <= lap_bcd;
      end
   end

   assign best_bcd = best_q;
   assign disp_src = disp_sel ? best_q : race_bcd;
`else
   logic unused_nobest;

   assign unused_nobest = ^{disp_sel, lap_bcd};
   assign best_bcd      = '0;
   assign disp_src      = race_bcd;
`endif

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         disp_q <= '0;
      end else begin
         disp_q <= disp_src;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      logic [6:0] seg_raw;

      hex7seg u_hex (
         .hex  (disp_q[g*BCD_W +: BCD_W]),
         .segs (seg_raw)
      );

      assign hex_segs[g*7 +: 7] = (disp_q[g*BCD_W +: BCD_W] > 4'd9) ? SEG_BLANK : seg_raw;
   end

endmodule

// File: tb/tb_lap_timer_display.sv
// Self-checking bench for lap_timer_display: integer race model compared every
// cycle, plus literal expectations and a 2-digit instance for saturation.
module tb_lap_timer_display;

   localparam int CLK_HZ   = 100;
   localparam int TICK_HZ  = 10;
   localparam int ND       = 4;
   localparam int NL       = 3;
   localparam int DIV      = CLK_HZ / TICK_HZ;
   localparam int MAXV     = 9999;
`ifdef BEST_LAP_EN
   localparam bit BEST     = 1'b1;
`else
   localparam bit BEST     = 1'b0;
`endif

   logic        Clock;
   logic        Resetn;
   logic        start_pulse;
   logic        lap_pulse;
   logic        disp_sel;
   logic        running;
   logic        race_done;
   logic [3:0]  lap_count;
   logic [15:0] race_bcd;
   logic [15:0] best_bcd;
   logic [27:0] hex_segs;

   logic        start_s;
   logic        lap_s;
   logic        sel_s;
   logic        running_s;
   logic        done_s;
   logic [3:0]  lap_count_s;
   logic [7:0]  race_s;
   logic [7:0]  best_s;
   logic [13:0] hex_s;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   int m_ph, m_race, m_lap, m_laps, m_cnt, m_best, m_disp;

   lap_timer_display #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_DIGITS(ND), .NUM_LAPS(NL)) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .start_pulse (start_pulse),
      .lap_pulse   (lap_pulse),
      .disp_sel    (disp_sel),
      .running     (running),
      .race_done   (race_done),
      .lap_count   (lap_count),
      .race_bcd    (race_bcd),
      .best_bcd    (best_bcd),
      .hex_segs    (hex_segs)
   );

   lap_timer_display #(.CLK_HZ(20), .TICK_HZ(10), .NUM_DIGITS(2), .NUM_LAPS(1)) dut_sat (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .start_pulse (start_s),
      .lap_pulse   (lap_s),
      .disp_sel    (sel_s),
      .running     (running_s),
      .race_done   (done_s),
      .lap_count   (lap_count_s),
      .race_bcd    (race_s),
      .best_bcd    (best_s),
      .hex_segs    (hex_s)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] res;
      int          x;
      res = '0;
      x   = v;
      for (int i = 0; i < ND; i++) begin
         res[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return res;
   endfunction

   function automatic logic [6:0] lit_segs(input int d);
      logic [6:0] on;
      case (d)
         0: on = 7'h3F;
         1: on = 7'h06;
         2: on = 7'h5B;
         3: on = 7'h4F;
         4: on = 7'h66;
         5: on = 7'h6D;
         6: on = 7'h7D;
         7: on = 7'h07;
         8: on = 7'h7F;
         9: on = 7'h6F;
         default: on = 7'h00;
      endcase
      return ~on;
   endfunction

   function automatic logic [31:0] segs_of(input int v);
      logic [31:0] res;
      int          x;
      res = '0;
      x   = v;
      for (int i = 0; i < ND; i++) begin
         res[7*i +: 7] = lit_segs(x % 10);
         x = x / 10;
      end
      return res;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 running, 2 finished; times kept as tick counts.
   always @(posedge Clock or negedge Resetn) begin : model
      int r, l, n, b, c, ph;
      bit tk;
      if (!Resetn) begin
         m_ph   <= 0;
         m_race <= 0;
         m_lap  <= 0;
         m_laps <= 0;
         m_cnt  <= 0;
         m_best <= MAXV;
         m_disp <= 0;
      end else begin
         r  = m_race;
         l  = m_lap;
         n  = m_laps;
         b  = m_best;
         c  = m_cnt;
         ph = m_ph;
         tk = (ph == 1) && (c == DIV - 1);
         if (ph != 1) begin
            if (start_pulse) begin
               ph = 1; r = 0; l = 0; n = 0; c = 0;
            end
         end else begin
            c = tk ? 0 : c + 1;
            if (tk && r < MAXV) r = r + 1;
            if (lap_pulse) begin
               n = n + 1;
               if (l < b) b = l;
               l = 0;
               if (n == NL) ph = 2;
            end else if (tk && l < MAXV) begin
               l = l + 1;
            end
         end
         m_disp <= (BEST && disp_sel) ? m_best : m_race;
         m_race <= r;
         m_lap  <= l;
         m_laps <= n;
         m_best <= b;
         m_cnt  <= c;
         m_ph   <= ph;
      end
   end

   always @(negedge Clock) begin
      if (chk_en) begin
         check("race_bcd",  race_bcd,  to_bcd(m_race));
         check("best_bcd",  best_bcd,  BEST ? to_bcd(m_best) : 32'h0);
         check("lap_count", lap_count, m_laps);
         check("running",   running,   m_ph == 1);
         check("race_done", race_done, m_ph == 2);
         check("hex_segs",  hex_segs,  segs_of(m_disp));
      end
   end

   task automatic pulse_start();
      start_pulse = 1'b1;
      @(negedge Clock);
      start_pulse = 1'b0;
   endtask

   task automatic pulse_lap(input int wait_cycles);
      repeat (wait_cycles) @(negedge Clock);
      lap_pulse = 1'b1;
      @(negedge Clock);
      lap_pulse = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      #2 Resetn = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
   endtask

   initial begin
      Resetn      = 1'b1;
      start_pulse = 1'b0;
      lap_pulse   = 1'b0;
      disp_sel    = 1'b0;
      start_s     = 1'b0;
      lap_s       = 1'b0;
      sel_s       = 1'b0;
      #1 Resetn   = 1'b0;
      repeat (2) @(negedge Clock);
      chk_en = 1'b1;
      Resetn = 1'b1;
      @(negedge Clock);
      check("rst race",  race_bcd,  32'h0000);
      check("rst best",  best_bcd,  BEST ? 32'h9999 : 32'h0);
      check("rst run",   running,   32'h0);
      check("rst done",  race_done, 32'h0);
      check("rst laps",  lap_count, 32'h0);
      check("rst segs",  hex_segs,  {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});

      pulse_start();
      repeat (990) @(negedge Clock);
      check("cnt 0099", race_bcd, 32'h0099);
      repeat (10) @(negedge Clock);
      check("cnt 0100", race_bcd, 32'h0100);
      repeat (230) @(negedge Clock);
      check("cnt 0123", race_bcd, 32'h0123);
      check("cnt run",  running,  32'h1);

      do_reset();
      pulse_start();
      pulse_lap(400);
      pulse_lap(249);
      pulse_lap(299);
      check("laps best", best_bcd,  BEST ? 32'h0025 : 32'h0);
      check("laps cnt",  lap_count, 32'h3);
      check("laps done", race_done, 32'h1);
      check("laps run",  running,   32'h0);
      check("laps race", race_bcd,  32'h0095);
      for (int i = 0; i < 100; i++) begin
         lap_pulse = (i % 7 == 3);
         @(negedge Clock);
      end
      lap_pulse = 1'b0;
      check("frozen race", race_bcd,  32'h0095);
      check("frozen laps", lap_count, 32'h3);
      check("frozen best", best_bcd,  BEST ? 32'h0025 : 32'h0);

      pulse_start();
      check("restart race", race_bcd,  32'h0000);
      check("restart laps", lap_count, 32'h0);
      check("restart best", best_bcd,  BEST ? 32'h0025 : 32'h0);
      check("restart run",  running,   32'h1);
      pulse_lap(79);
      check("simul best", best_bcd,  BEST ? 32'h0007 : 32'h0);
      check("simul race", race_bcd,  32'h0008);
      check("simul laps", lap_count, 32'h1);
      pulse_lap(0);
      check("lap zero best", best_bcd,  BEST ? 32'h0000 : 32'h0);
      check("lap zero laps", lap_count, 32'h2);

      repeat (15) @(negedge Clock);
      @(posedge Clock);
      #2 Resetn = 1'b0;
      #1;
      check("async race", race_bcd,  32'h0000);
      check("async best", best_bcd,  BEST ? 32'h9999 : 32'h0);
      check("async run",  running,   32'h0);
      check("async laps", lap_count, 32'h0);
      check("async done", race_done, 32'h0);
      check("async segs", hex_segs,  {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
      @(negedge Clock);
      Resetn = 1'b1;

      start_s = 1'b1;
      @(negedge Clock);
      start_s = 1'b0;
      repeat (196) @(negedge Clock);
      check("sat 98", race_s, 32'h98);
      repeat (2) @(negedge Clock);
      check("sat 99", race_s, 32'h99);
      repeat (50) @(negedge Clock);
      check("sat hold", race_s,      32'h99);
      check("sat run",  running_s,   32'h1);
      check("sat segs", hex_s,       {7'h10, 7'h10});
      check("sat best", best_s,      BEST ? 32'h99 : 32'h0);
      check("sat done", done_s,      32'h0);
      check("sat laps", lap_count_s, 32'h0);

      for (int i = 0; i < 4000; i++) begin
         @(negedge Clock);
         start_pulse = ($urandom_range(0, 99) < 2);
         lap_pulse   = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 49) == 0) disp_sel = ~disp_sel;
         if (i == 2000) begin
            #2 Resetn = 1'b0;
            @(negedge Clock);
            Resetn = 1'b1;
         end
      end
      start_pulse = 1'b0;
      lap_pulse   = 1'b0;
      repeat (3) @(negedge Clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
